// File: rtl/mask_loader.sv
// -----------------------------------------------------------------------------
// mask_loader
//
// Upstream stage of the mask register. Accepts a valid/ready byte stream that
// carries a MAX_N x MAX_N weight mask, and writes each byte to the mask
// register write port one cycle after it is accepted. While loading, it counts
// the set mask bits for the order-statistic rank logic. When the last write
// has landed, it flags that the mask is complete and stable.
//
// Ports
//   clk         clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   start       begin a new mask load (1-cycle pulse, ignored while busy)
//   abort       abandon the current load (wins over start)
//   in_data     mask byte from upstream
//   in_valid    in_data valid
//   in_ready    loader accepts a byte this cycle (LOAD state only)
//   wr_addr     mask register byte address
//   wr_en       mask register write enable
//   wr_data     mask register write data
//   busy        load in progress (LOAD and FLUSH)
//   load_done   1-cycle pulse: mask fully written and visible
//   mask_valid  level: last load completed, mask stable
//   ones_count  number of set mask bits (meaningful while mask_valid)
// -----------------------------------------------------------------------------
module mask_loader #(
  parameter  int MAX_N      = 9,
  parameter  int INPUT_SIZE = 8,
  localparam int MASK_BITS  = MAX_N * MAX_N,
  localparam int MEM_SIZE   = (MASK_BITS + INPUT_SIZE - 1) / INPUT_SIZE,
  localparam int ADDR_BITS  = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1,
  localparam int CNT_BITS   = $clog2(MASK_BITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [INPUT_SIZE-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_BITS-1:0]  wr_addr,
  output logic                  wr_en,
  output logic [INPUT_SIZE-1:0] wr_data,
  output logic                  busy,
  output logic                  load_done,
  output logic                  mask_valid,
  output logic [CNT_BITS-1:0]   ones_count
);

  // Number of real mask bits carried by the final byte; the rest is padding.
  localparam int LAST_BITS = MASK_BITS - INPUT_SIZE * (MEM_SIZE - 1);

  localparam logic [ADDR_BITS-1:0]  LAST_ADDR = ADDR_BITS'(MEM_SIZE - 1);
  localparam logic [INPUT_SIZE-1:0] LAST_MASK =
    {INPUT_SIZE{1'b1}} >> (INPUT_SIZE - LAST_BITS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [ADDR_BITS-1:0]   byte_cnt;
  logic                   accept;
  logic                   last_byte;
  logic                   start_ok;
  logic                   finish;
  logic [INPUT_SIZE-1:0]  counted_bits;
  logic [CNT_BITS-1:0]    byte_ones;

  function automatic logic [CNT_BITS-1:0] popcount(input logic [INPUT_SIZE-1:0] v);
    logic [CNT_BITS-1:0] sum;
    sum = '0;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      sum = sum + CNT_BITS'(v[i]);
    end
    return sum;
  endfunction

  // A start only counts in IDLE, and abort in the same cycle cancels it.
  assign start_ok  = start & ~abort & (state == IDLE);
  assign accept    = in_valid & in_ready;
  assign last_byte = (byte_cnt == LAST_ADDR);
  // FLUSH is the cycle in which the final write is on the port; leaving it
  // cleanly means the mask becomes visible at the next edge.
  assign finish    = (state == FLUSH) & ~abort;

  // Padding bits of the final byte are written out unchanged, but they are
  // not part of the mask, so they must not be counted.
  always_comb begin
    counted_bits = in_data;
    if (last_byte) begin
      counted_bits = in_data & LAST_MASK;
    end
    byte_ones = popcount(counted_bits);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded handshake/status outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else if (accept && last_byte) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Byte counter. It saturates at the last address so a stray accept can
  // never produce an address outside the mask register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
    end else if (start_ok || abort) begin
      byte_cnt <= '0;
    end else if (accept && !last_byte) begin
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

  // Write port: each accepted byte is presented for exactly one cycle.
  // A write registered just before an abort still goes out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= byte_cnt;
        wr_data <= in_data;
      end
    end
  end

  // Running count of set mask bits; the final sum lands with the last write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_count <= '0;
    end else if (start_ok) begin
      ones_count <= '0;
    end else if (accept) begin
      ones_count <= ones_count + byte_ones;
    end
  end

  // Completion flags: load_done pulses once, mask_valid holds until the next
  // start or any abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_done  <= 1'b0;
      mask_valid <= 1'b0;
    end else begin
      load_done <= finish;
      if (abort || start_ok) begin
        mask_valid <= 1'b0;
      end else if (finish) begin
        mask_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mask_loader.sv
// -----------------------------------------------------------------------------
// tb_mask_loader
//
// Self-checking bench for mask_loader. Writes seen on the mask register port are
// logged and replayed into a model memory. Expected counts and mask bits come
// from the bytes the bench sent, which are decoded into the mask using the
// stated bit order.
// -----------------------------------------------------------------------------
module tb_mask_loader;

  localparam int MAX_N      = 9;
  localparam int INPUT_SIZE = 8;
  localparam int MASK_BITS  = MAX_N * MAX_N;
  localparam int MEM_SIZE   = (MASK_BITS + INPUT_SIZE - 1) / INPUT_SIZE;
  localparam int ADDR_BITS  = $clog2(MEM_SIZE);
  localparam int CNT_BITS   = $clog2(MASK_BITS + 1);

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic                  abort = 1'b0;
  logic [INPUT_SIZE-1:0] in_data = '0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [ADDR_BITS-1:0]  wr_addr;
  logic                  wr_en;
  logic [INPUT_SIZE-1:0] wr_data;
  logic                  busy;
  logic                  load_done;
  logic                  mask_valid;
  logic [CNT_BITS-1:0]   ones_count;

  mask_loader #(.MAX_N(MAX_N), .INPUT_SIZE(INPUT_SIZE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_addr    (wr_addr),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .busy       (busy),
    .load_done  (load_done),
    .mask_valid (mask_valid),
    .ones_count (ones_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t                   wq[$];
  logic [INPUT_SIZE-1:0] mem  [MEM_SIZE];
  logic [INPUT_SIZE-1:0] sent [MEM_SIZE];
  int                    cyc = 0;
  int                    ld_cnt = 0;
  int                    ld_cyc = 0;
  int                    pass_cnt = 0;
  int                    total_cnt = 0;
  int                    tmo;
  int                    last_acc;

  // Edge counter used to time-stamp writes and load_done pulses.
  always @(posedge clk) cyc <= cyc + 1;

  // Port monitor: one sample per cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        wq.push_back('{int'(wr_addr), int'(wr_data), cyc});
        if (int'(wr_addr) < MEM_SIZE) mem[wr_addr] = wr_data;
      end
      if (load_done) begin
        ld_cnt++;
        ld_cyc = cyc;
      end
    end
  end

  // Byte k bit j is mask bit MASK_BITS-1-(8k+j); bits past MASK_BITS are padding.
  function automatic logic [MASK_BITS-1:0] to_mask(input logic [INPUT_SIZE-1:0] b [MEM_SIZE]);
    logic [MASK_BITS-1:0] m;
    m = '0;
    for (int k = 0; k < MEM_SIZE; k++) begin
      for (int j = 0; j < INPUT_SIZE; j++) begin
        if (k * INPUT_SIZE + j < MASK_BITS) m[MASK_BITS-1-(k*INPUT_SIZE+j)] = b[k][j];
      end
    end
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wq.delete();
    for (int k = 0; k < MEM_SIZE; k++) mem[k] = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Presents sent[first..last]; gap_pct is the chance of an idle cycle before
  // each byte. Any cycle where in_ready is unexpectedly low counts in tmo.
  task automatic drive_bytes(input int first, input int last, input int gap_pct);
    for (int k = first; k <= last; k++) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        step();
      end
      in_valid = 1'b1;
      in_data  = sent[k];
      if (in_ready !== 1'b1) tmo++;
      step();
      last_acc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total_cnt++;
    if ({in_ready, wr_en, busy, load_done, mask_valid, wr_addr, wr_data, ones_count} !== '0)
      $display("[TB] FAIL reset_outputs: got %0h expected 0",
               {in_ready, wr_en, busy, load_done, mask_valid, wr_addr, wr_data, ones_count});
    else pass_cnt++;
    #5 rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_ones();
    logic [MASK_BITS-1:0] m;
    int ld0;
    for (int k = 0; k < MEM_SIZE; k++) sent[k] = 8'hFF;
    clear_log();
    ld0 = ld_cnt;
    tmo = 0;
    pulse_start();
    total_cnt++;
    if (busy !== 1'b1 || in_ready !== 1'b1)
      $display("[TB] FAIL start_busy: got busy=%b ready=%b expected 1 1", busy, in_ready);
    else pass_cnt++;
    drive_bytes(0, MEM_SIZE - 1, 0);
    total_cnt++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || load_done !== 1'b0)
      $display("[TB] FAIL flush_state: got busy=%b ready=%b done=%b expected 1 0 0",
               busy, in_ready, load_done);
    else pass_cnt++;
    step();
    total_cnt++;
    if (load_done !== 1'b1 || busy !== 1'b0 || mask_valid !== 1'b1 || ones_count !== 7'd81)
      $display("[TB] FAIL ones_done: got done=%b busy=%b mv=%b cnt=%0d expected 1 0 1 81",
               load_done, busy, mask_valid, ones_count);
    else pass_cnt++;
    step();
    total_cnt++;
    if (load_done !== 1'b0 || mask_valid !== 1'b1)
      $display("[TB] FAIL done_pulse: got done=%b mv=%b expected 0 1", load_done, mask_valid);
    else pass_cnt++;
    total_cnt++;
    if (ld_cnt - ld0 !== 1 || ld_cyc - last_acc !== 1 || tmo !== 0)
      $display("[TB] FAIL done_timing: got pulses=%0d edges_after_last=%0d stalls=%0d expected 1 1 0",
               ld_cnt - ld0, ld_cyc - last_acc, tmo);
    else pass_cnt++;
    total_cnt++;
    if (wq.size() !== MEM_SIZE)
      $display("[TB] FAIL ones_writes: got %0d writes expected %0d", wq.size(), MEM_SIZE);
    else begin
      int bad;
      bad = 0;
      foreach (wq[i]) if (wq[i].addr != i || wq[i].cyc != wq[0].cyc + i) bad++;
      if (bad != 0) $display("[TB] FAIL ones_addr_seq: got %0d out-of-sequence writes expected 0", bad);
      else pass_cnt++;
    end
    m = to_mask(mem);
    total_cnt++;
    if (m !== {MASK_BITS{1'b1}}) $display("[TB] FAIL ones_mask: got %h expected all ones", m);
    else pass_cnt++;
  endtask

  task automatic test_padding();
    logic [MASK_BITS-1:0] m;
    sent[0] = 8'h01;
    for (int k = 1; k < MEM_SIZE - 1; k++) sent[k] = 8'h00;
    sent[MEM_SIZE-1] = 8'hFE;
    clear_log();
    tmo = 0;
    pulse_start();
    drive_bytes(0, MEM_SIZE - 1, 0);
    step();
    total_cnt++;
    if (load_done !== 1'b1 || ones_count !== 7'd1)
      $display("[TB] FAIL padding_count: got done=%b cnt=%0d expected 1 1", load_done, ones_count);
    else pass_cnt++;
    m = to_mask(mem);
    total_cnt++;
    if (m[MASK_BITS-1] !== 1'b1 || m[0] !== 1'b0 || mem[MEM_SIZE-1] !== 8'hFE)
      $display("[TB] FAIL padding_bits: got msb=%b lsb=%b last=%h expected 1 0 fe",
               m[MASK_BITS-1], m[0], mem[MEM_SIZE-1]);
    else pass_cnt++;
    step();
  endtask

  task automatic test_random_gaps();
    for (int r = 0; r < 4; r++) begin
      int bad;
      for (int k = 0; k < MEM_SIZE; k++) sent[k] = 8'($urandom);
      clear_log();
      tmo = 0;
      pulse_start();
      drive_bytes(0, MEM_SIZE - 1, 50);
      step();
      total_cnt++;
      if (load_done !== 1'b1 || mask_valid !== 1'b1 ||
          int'(ones_count) !== $countones(to_mask(sent)) || tmo !== 0)
        $display("[TB] FAIL gaps_count[%0d]: got done=%b mv=%b cnt=%0d stalls=%0d expected 1 1 %0d 0",
                 r, load_done, mask_valid, ones_count, tmo, $countones(to_mask(sent)));
      else pass_cnt++;
      bad = 0;
      foreach (wq[i]) if (wq[i].addr != i || wq[i].data != int'(sent[i])) bad++;
      total_cnt++;
      if (wq.size() !== MEM_SIZE || bad !== 0)
        $display("[TB] FAIL gaps_writes[%0d]: got %0d writes %0d wrong expected %0d 0",
                 r, wq.size(), bad, MEM_SIZE);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_abort();
    int ld0;
    for (int k = 0; k < MEM_SIZE; k++) sent[k] = 8'($urandom);
    clear_log();
    ld0 = ld_cnt;
    tmo = 0;
    pulse_start();
    drive_bytes(0, 4, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || in_ready !== 1'b0)
      $display("[TB] FAIL abort_idle: got busy=%b ready=%b expected 0 0", busy, in_ready);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) step();
    total_cnt++;
    if (ld_cnt !== ld0 || mask_valid !== 1'b0 || wq.size() !== 5)
      $display("[TB] FAIL abort_effect: got pulses=%0d mv=%b writes=%0d expected 0 0 5",
               ld_cnt - ld0, mask_valid, wq.size());
    else pass_cnt++;
    for (int k = 0; k < MEM_SIZE; k++) sent[k] = 8'($urandom);
    clear_log();
    pulse_start();
    drive_bytes(0, MEM_SIZE - 1, 30);
    step();
    total_cnt++;
    if (load_done !== 1'b1 || int'(ones_count) !== $countones(to_mask(sent)) || wq.size() !== MEM_SIZE)
      $display("[TB] FAIL abort_reload: got done=%b cnt=%0d writes=%0d expected 1 %0d %0d",
               load_done, ones_count, wq.size(), $countones(to_mask(sent)), MEM_SIZE);
    else pass_cnt++;
    step();
  endtask

  task automatic test_start_ignored();
    int bad;
    int ld0;
    for (int k = 0; k < MEM_SIZE; k++) sent[k] = 8'($urandom);
    clear_log();
    tmo = 0;
    pulse_start();
    drive_bytes(0, 5, 40);
    pulse_start();
    drive_bytes(6, MEM_SIZE - 1, 40);
    step();
    bad = 0;
    foreach (wq[i]) if (wq[i].addr != i || wq[i].data != int'(sent[i])) bad++;
    total_cnt++;
    if (load_done !== 1'b1 || int'(ones_count) !== $countones(to_mask(sent)) ||
        wq.size() !== MEM_SIZE || bad !== 0 || tmo !== 0)
      $display("[TB] FAIL restart_ignored: got done=%b cnt=%0d writes=%0d wrong=%0d expected 1 %0d %0d 0",
               load_done, ones_count, wq.size(), bad, $countones(to_mask(sent)), MEM_SIZE);
    else pass_cnt++;
    step();
    clear_log();
    ld0 = ld_cnt;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || in_ready !== 1'b0)
      $display("[TB] FAIL start_abort_idle: got busy=%b ready=%b expected 0 0", busy, in_ready);
    else pass_cnt++;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    in_valid = 1'b0;
    total_cnt++;
    if (wq.size() !== 0 || ld_cnt !== ld0 || busy !== 1'b0)
      $display("[TB] FAIL start_abort_noop: got writes=%0d pulses=%0d busy=%b expected 0 0 0",
               wq.size(), ld_cnt - ld0, busy);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < MEM_SIZE; k++) sent[k] = 8'($urandom) | 8'h01;
    clear_log();
    pulse_start();
    drive_bytes(0, 3, 0);
    #3 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({in_ready, wr_en, busy, load_done, mask_valid, wr_addr, wr_data, ones_count} !== '0)
      $display("[TB] FAIL async_reset: got %0h expected 0",
               {in_ready, wr_en, busy, load_done, mask_valid, wr_addr, wr_data, ones_count});
    else pass_cnt++;
    #2 rst_n = 1'b1;
    clear_log();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    in_valid = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || wq.size() !== 0)
      $display("[TB] FAIL post_reset_idle: got ready=%b busy=%b writes=%0d expected 0 0 0",
               in_ready, busy, wq.size());
    else pass_cnt++;
    clear_log();
    pulse_start();
    drive_bytes(0, MEM_SIZE - 1, 20);
    step();
    total_cnt++;
    if (load_done !== 1'b1 || int'(ones_count) !== $countones(to_mask(sent)))
      $display("[TB] FAIL post_reset_load: got done=%b cnt=%0d expected 1 %0d",
               load_done, ones_count, $countones(to_mask(sent)));
    else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_full_ones();
    test_padding();
    test_random_gaps();
    test_abort();
    test_start_ignored();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard stop in case a wait never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
